// File: rtl/model_pkg.sv
// rtl/model_pkg.sv - opcodes, FSM state type and IR field positions for the model machine
package model_pkg;

  localparam int IW_DEF = 8;
  localparam int CW_DEF = 16;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RD_HI  = 3;
  localparam int RD_LO  = 2;
  localparam int RS_HI  = 1;
  localparam int RS_LO  = 0;

  localparam logic [3:0] OP_MOVA = 4'h1;
  localparam logic [3:0] OP_MOVB = 4'h2;
  localparam logic [3:0] OP_MOVC = 4'h3;
  localparam logic [3:0] OP_MOVD = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JG   = 4'h8;
  localparam logic [3:0] OP_IN1  = 4'h9;
  localparam logic [3:0] OP_OUT1 = 4'hA;
  localparam logic [3:0] OP_MOVI = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hC;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/ir_sequencer_if.sv
// rtl/ir_sequencer_if.sv - controller <-> sequencer signal bundle
interface ir_sequencer_if #(
  parameter int IW = 8,
  parameter int CW = 16
);
  logic [IW-1:0] ram_data;
  logic          ld_ir;
  logic          sm_en;
  logic          sm;
  logic          mova, movb, movc, movd, add, sub;
  logic          jmp, jg, in1, out1, movi, halt;
  logic [1:0]    rd;
  logic [1:0]    rs;
  logic [IW-1:0] ir;
  logic          halted;
  logic          illegal;
  logic [CW-1:0] instr_cnt;

  modport master (
    output ram_data, ld_ir, sm_en,
    input  sm, mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt,
    input  rd, rs, ir, halted, illegal, instr_cnt
  );

  modport slave (
    input  ram_data, ld_ir, sm_en,
    output sm, mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt,
    output rd, rs, ir, halted, illegal, instr_cnt
  );
endinterface

// File: rtl/op_decode.sv
// rtl/op_decode.sv - opcode to one-hot instruction lines; unlisted opcodes raise op_illegal
module op_decode
  import model_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       mova,
  output logic       movb,
  output logic       movc,
  output logic       movd,
  output logic       add,
  output logic       sub,
  output logic       jmp,
  output logic       jg,
  output logic       in1,
  output logic       out1,
  output logic       movi,
  output logic       halt,
  output logic       op_illegal
);

  always_comb begin
    mova       = 1'b0;
    movb       = 1'b0;
    movc       = 1'b0;
    movd       = 1'b0;
    add        = 1'b0;
    sub        = 1'b0;
    jmp        = 1'b0;
    jg         = 1'b0;
    in1        = 1'b0;
    out1       = 1'b0;
    movi       = 1'b0;
    halt       = 1'b0;
    op_illegal = 1'b0;
    case (opcode)
      OP_MOVA: mova = 1'b1;
      OP_MOVB: movb = 1'b1;
      OP_MOVC: movc = 1'b1;
      OP_MOVD: movd = 1'b1;
      OP_ADD:  add  = 1'b1;
      OP_SUB:  sub  = 1'b1;
      OP_JMP:  jmp  = 1'b1;
      OP_JG:   jg   = 1'b1;
      OP_IN1:  in1  = 1'b1;
      OP_OUT1: out1 = 1'b1;
      OP_MOVI: movi = 1'b1;
      OP_HALT: halt = 1'b1;
      default: op_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ir_sequencer.sv
// rtl/ir_sequencer.sv - instruction register, fetch/exec/halt sequencer and retire/illegal status
module ir_sequencer
  import model_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ir_sequencer_if.slave bus
);

  state_t        state;
  logic [IW-1:0] ir_q;
  logic [CW-1:0] cnt_q;
  logic          illegal_q;
  logic          sm_q;
  logic          halted_q;
  logic          op_illegal;

  // Decode depends only on the IR register, so there is no input-to-output path.
  op_decode u_dec (
    .opcode     (ir_q[OPC_HI:OPC_LO]),
    .mova       (bus.mova),
    .movb       (bus.movb),
    .movc       (bus.movc),
    .movd       (bus.movd),
    .add        (bus.add),
    .sub        (bus.sub),
    .jmp        (bus.jmp),
    .jg         (bus.jg),
    .in1        (bus.in1),
    .out1       (bus.out1),
    .movi       (bus.movi),
    .halt       (bus.halt),
    .op_illegal (op_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      sm_q      <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.ld_ir) ir_q <= bus.ram_data;
          if (bus.sm_en) begin
            state <= EXEC;
            sm_q  <= 1'b1;
          end
        end
        EXEC: begin
          if (op_illegal) illegal_q <= 1'b1;
          // Halt takes priority over sm_en and never counts as retired.
          if (bus.halt) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else if (bus.sm_en) begin
            state <= FETCH;
            sm_q  <= 1'b0;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state    <= FETCH;
          sm_q     <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sm        = sm_q;
  assign bus.halted    = halted_q;
  assign bus.ir        = ir_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.illegal   = illegal_q;
  assign bus.rd        = ir_q[RD_HI:RD_LO];
  assign bus.rs        = ir_q[RS_HI:RS_LO];

endmodule
